// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline control logic: opcodes,
// instruction field positions, the NOP encoding and the sequencer states.
package mips32_pkg;

  localparam logic [5:0] OP_LD   = 6'b110000;
  localparam logic [5:0] OP_ST   = 6'b110001;
  localparam logic [5:0] OP_BEQZ = 6'b110100;
  localparam logic [5:0] OP_BNEZ = 6'b110101;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;

  // add r0,r0,r0
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  function automatic logic [5:0] op_of(input logic [31:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] ir);
    return ir[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] ir);
    return ir[RS2_HI:RS2_LO];
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard resolution over the ID and EX instructions:
// load-use stall, taken-branch squash (which wins over load-use) and
// halt request. State gating is applied by the sequencer.
module hazard_detect
  import mips32_pkg::*;
(
  input  logic [31:0] id_ir,
  input  logic [31:0] ex_ir,
  input  logic        br_taken,
  output logic        if_stall,
  output logic        ifid_flush,
  output logic        id_bubble,
  output logic        halt_req
);

  logic       load_use;
  logic [5:0] id_op;
  logic [5:0] ex_op;
  logic [4:0] ex_rd;
  logic       unused_bits;

  // Only opcode and rd of the EX instruction and the register fields of ID matter.
  assign unused_bits = ^{ex_ir[20:0], id_ir[10:0]};

  // Detect a load in EX whose destination feeds a source of the ID instruction.
  always_comb begin
    id_op    = op_of(id_ir);
    ex_op    = op_of(ex_ir);
    ex_rd    = rd_of(ex_ir);
    load_use = 1'b0;
    if ((ex_op == OP_LD) && (ex_rd != 5'd0)) begin
      if ((id_op != OP_HLT) && (rs1_of(id_ir) == ex_rd)) begin
        load_use = 1'b1;
      end else if ((id_ir[31:30] == 2'b00) && (rs2_of(id_ir) == ex_rd)) begin
        load_use = 1'b1;
      end else if ((id_op == OP_ST) && (rd_of(id_ir) == ex_rd)) begin
        load_use = 1'b1;
      end else begin
        load_use = 1'b0;
      end
    end else begin
      load_use = 1'b0;
    end
  end

  // Resolve stall/flush/bubble; a taken branch redirects the PC, so no stall.
  always_comb begin
    if_stall   = 1'b0;
    ifid_flush = 1'b0;
    id_bubble  = 1'b0;
    halt_req   = 1'b0;
    if (br_taken) begin
      ifid_flush = 1'b1;
      id_bubble  = 1'b1;
    end else if (load_use) begin
      if_stall  = 1'b1;
      id_bubble = 1'b1;
    end else begin
      if_stall = 1'b0;
    end
    // HLT behind a taken branch is on the wrong path and is squashed.
    if ((op_of(id_ir) == OP_HLT) && !br_taken) begin
      halt_req = 1'b1;
    end else begin
      halt_req = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: streams a program into instruction memory, releases
// the pipeline, gates hazard controls by state and drains on halt.
module pipe_ctrl
  import mips32_pkg::*;
#(
  parameter int IMEM_AW   = 10,
  parameter int DRAIN_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_valid,
  input  logic [31:0]        prog_data,
  output logic               prog_ready,
  input  logic               run_start,
  input  logic [31:0]        id_ir,
  input  logic [31:0]        ex_ir,
  input  logic               br_taken,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               pc_rst,
  output logic               stage_en,
  output logic               if_stall,
  output logic               ifid_flush,
  output logic               id_bubble,
  output logic               halted,
  output logic [31:0]        run_cycles
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t             state;
  state_t             next_state;
  logic [IMEM_AW-1:0] addr;
  logic               full;
  logic [DCW-1:0]     drain_cnt;
  logic               loadable;
  logic               accept;
  logic               start;
  logic               hz_stall;
  logic               hz_flush;
  logic               hz_bubble;
  logic               halt_req;

  hazard_detect u_hazard (
    .id_ir      (id_ir),
    .ex_ir      (ex_ir),
    .br_taken   (br_taken),
    .if_stall   (hz_stall),
    .ifid_flush (hz_flush),
    .id_bubble  (hz_bubble),
    .halt_req   (halt_req)
  );

  assign loadable   = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_HALTED);
  assign prog_ready = loadable && !full;
  assign accept     = prog_valid && prog_ready;
  assign start      = run_start && loadable;
  assign imem_we    = accept;
  // A reload after a halt always restarts at address 0.
  assign imem_addr  = (state == ST_HALTED) ? {IMEM_AW{1'b0}} : addr;
  assign imem_wdata = prog_data;

  // Next-state selection for the sequencer.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          next_state = ST_RUN;
        end else if (accept) begin
          next_state = ST_LOAD;
        end else begin
          next_state = state;
        end
      end
      ST_LOAD: begin
        if (start) begin
          next_state = ST_RUN;
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          next_state = (DRAIN_CYC > 1) ? ST_DRAIN : ST_HALTED;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // The counter reaches 0 on the same edge that enters HALTED.
        if (drain_cnt <= DCW'(1)) begin
          next_state = ST_HALTED;
        end else begin
          next_state = ST_DRAIN;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Hazard controls are live only while the pipeline is moving.
  always_comb begin
    if_stall   = 1'b0;
    ifid_flush = 1'b0;
    id_bubble  = 1'b0;
    case (state)
      ST_RUN: begin
        if_stall   = hz_stall;
        ifid_flush = hz_flush;
        id_bubble  = hz_bubble;
      end
      ST_DRAIN: begin
        if_stall  = 1'b1;
        id_bubble = 1'b1;
      end
      default: begin
        if_stall   = 1'b0;
        ifid_flush = 1'b0;
        id_bubble  = 1'b0;
      end
    endcase
  end

  // State register and registered pipeline-level outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc_rst   <= 1'b0;
      stage_en <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= next_state;
      pc_rst   <= start;
      stage_en <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
      halted   <= (next_state == ST_HALTED);
    end
  end

  // Program address counter with sticky full flag; it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= {IMEM_AW{1'b0}};
      full <= 1'b0;
    end else if (start) begin
      addr <= {IMEM_AW{1'b0}};
      full <= 1'b0;
    end else if (accept) begin
      if (imem_addr == {IMEM_AW{1'b1}}) begin
        addr <= imem_addr;
        full <= 1'b1;
      end else begin
        addr <= imem_addr + {{(IMEM_AW-1){1'b0}}, 1'b1};
        full <= 1'b0;
      end
    end else begin
      addr <= addr;
      full <= full;
    end
  end

  // Drain countdown after a halt is decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= {DCW{1'b0}};
    end else if ((state == ST_RUN) && halt_req) begin
      drain_cnt <= DCW'(DRAIN_CYC - 1);
    end else if ((state == ST_DRAIN) && (drain_cnt != {DCW{1'b0}})) begin
      drain_cnt <= drain_cnt - DCW'(1);
    end else begin
      drain_cnt <= drain_cnt;
    end
  end

  // Saturating count of RUN and DRAIN cycles since the last start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cycles <= 32'd0;
    end else if (start) begin
      run_cycles <= 32'd0;
    end else if (((state == ST_RUN) || (state == ST_DRAIN)) && (run_cycles != 32'hFFFF_FFFF)) begin
      run_cycles <= run_cycles + 32'd1;
    end else begin
      run_cycles <= run_cycles;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues expected memory writes and
// per-cycle control expectations; a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_valid = 1'b0;
  logic [31:0] prog_data = 32'd0;
  logic        prog_ready;
  logic        run_start = 1'b0;
  logic [31:0] id_ir = 32'd0;
  logic [31:0] ex_ir = 32'd0;
  logic        br_taken = 1'b0;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        pc_rst, stage_en, if_stall, ifid_flush, id_bubble, halted;
  logic [31:0] run_cycles;

  pipe_ctrl #(.IMEM_AW(10), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .run_start(run_start), .id_ir(id_ir), .ex_ir(ex_ir),
    .br_taken(br_taken), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc_rst(pc_rst), .stage_en(stage_en),
    .if_stall(if_stall), .ifid_flush(ifid_flush), .id_bubble(id_bubble),
    .halted(halted), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // control vector bit order: {prog_ready, imem_we, pc_rst, stage_en, if_stall, ifid_flush, id_bubble, halted}
  typedef struct {
    string       nm;
    int          at;
    logic [7:0]  exp;
    logic [7:0]  msk;
    bit          chk_rc;
    logic [31:0] rc;
  } ctl_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  ctl_t cq[$];
  wr_t  wq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic exp_ctl(input string nm, input logic [7:0] e, input logic [7:0] m,
                         input bit crc, input logic [31:0] rc);
    ctl_t r;
    r.nm = nm; r.at = cyc; r.exp = e; r.msk = m; r.chk_rc = crc; r.rc = rc;
    cq.push_back(r);
  endtask

  task automatic exp_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  // Monitor: compare memory writes and any control expectation due this cycle.
  ctl_t       mr;
  wr_t        mw;
  logic [7:0] act;
  always @(negedge clk) begin
    act = {prog_ready, imem_we, pc_rst, stage_en, if_stall, ifid_flush, id_bubble, halted};
    if (imem_we) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got write addr=%0d data=%h, want no write", imem_addr, imem_wdata);
      end else begin
        mw = wq.pop_front();
        if (imem_addr !== mw.addr || imem_wdata !== mw.data) begin
          n_fail++;
          $display("FAIL wr_beat: got addr=%0d data=%h, want addr=%0d data=%h",
                   imem_addr, imem_wdata, mw.addr, mw.data);
        end
      end
    end
    while (cq.size() > 0 && cq[0].at <= cyc) begin
      mr = cq.pop_front();
      n_chk++;
      if (mr.at < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", mr.nm, mr.at, cyc);
      end else if (((act & mr.msk) !== (mr.exp & mr.msk)) || (mr.chk_rc && run_cycles !== mr.rc)) begin
        n_fail++;
        $display("FAIL %s at cycle %0d: got ctl=%b run_cycles=%0d, want ctl=%b mask=%b run_cycles=%0d",
                 mr.nm, cyc, act, run_cycles, mr.exp, mr.msk, mr.rc);
      end
    end
  end

  typedef struct {
    string       nm;
    logic [31:0] id;
    logic [31:0] ex;
    logic        br;
    logic [2:0]  sfb;  // {if_stall, ifid_flush, id_bubble}
  } hz_t;

  hz_t hz[$];
  int  run_t0;
  int  t_hlt;
  logic [31:0] rc_h;
  logic [31:0] wd;

  initial begin
    // hazard vectors; LD=110000 ST=110001 HLT=111111 ADD=000000 ADDI-like=010000
    hz.push_back('{"lu_rs2",       ins(6'b000000,5'd5,5'd1,5'd3), ins(6'b110000,5'd3,5'd0,5'd0), 1'b0, 3'b101});
    hz.push_back('{"lu_rd0",       ins(6'b000000,5'd5,5'd0,5'd0), ins(6'b110000,5'd0,5'd0,5'd0), 1'b0, 3'b000});
    hz.push_back('{"lu_rs1_imm",   ins(6'b010000,5'd5,5'd3,5'd0), ins(6'b110000,5'd3,5'd0,5'd0), 1'b0, 3'b101});
    hz.push_back('{"lu_rs2_nonrr", ins(6'b010000,5'd5,5'd1,5'd3), ins(6'b110000,5'd3,5'd0,5'd0), 1'b0, 3'b000});
    hz.push_back('{"lu_st_rd",     ins(6'b110001,5'd3,5'd1,5'd0), ins(6'b110000,5'd3,5'd0,5'd0), 1'b0, 3'b101});
    hz.push_back('{"no_ld_in_ex",  ins(6'b000000,5'd5,5'd3,5'd0), ins(6'b110001,5'd3,5'd0,5'd0), 1'b0, 3'b000});
    hz.push_back('{"br_prio",      ins(6'b000000,5'd5,5'd1,5'd3), ins(6'b110000,5'd3,5'd0,5'd0), 1'b1, 3'b011});
    hz.push_back('{"br_only",      32'd0,                         32'd0,                         1'b1, 3'b011});
    hz.push_back('{"br_hlt",       ins(6'b111111,5'd0,5'd0,5'd0), 32'd0,                         1'b1, 3'b011});
    hz.push_back('{"after_br_hlt", 32'd0,                         32'd0,                         1'b0, 3'b000});

    // reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ctl("reset_state", 8'b1000_0000, 8'hFF, 1'b1, 32'd0);
    step();

    // load five words, then start
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = 32'hA000_0000 + i;
      exp_wr(10'(i), prog_data);
      exp_ctl("load_beat", 8'b1100_0000, 8'b1101_0001, 1'b0, 32'd0);
      step();
    end
    prog_valid = 1'b0;
    run_start  = 1'b1;
    exp_ctl("pre_run", 8'b1000_0000, 8'hF1, 1'b0, 32'd0);
    step();
    run_start = 1'b0;
    run_t0    = cyc;
    exp_ctl("run_entry", 8'b0011_0000, 8'hFF, 1'b1, 32'd0);
    step();
    exp_ctl("pc_rst_pulse_end", 8'b0001_0000, 8'hFF, 1'b1, 32'd1);
    step();

    // hazard vectors while running
    foreach (hz[k]) begin
      id_ir    = hz[k].id;
      ex_ir    = hz[k].ex;
      br_taken = hz[k].br;
      exp_ctl(hz[k].nm, {4'b0001, hz[k].sfb, 1'b0}, 8'hFF, 1'b1, 32'(cyc - run_t0));
      step();
    end

    // halt drain: HLT decoded at t, halted at t+4; run_start in DRAIN ignored
    id_ir = ins(6'b111111, 5'd0, 5'd0, 5'd0);
    ex_ir = 32'd0;
    br_taken = 1'b0;
    t_hlt = cyc;
    exp_ctl("hlt_decode", 8'b0001_0000, 8'hFF, 1'b1, 32'(cyc - run_t0));
    step();
    id_ir = 32'd0;
    run_start = 1'b1;
    for (int k = 1; k < 4; k++) begin
      exp_ctl("drain", 8'b0001_1010, 8'hFF, 1'b1, 32'(cyc - run_t0));
      step();
      run_start = 1'b0;
    end
    rc_h = 32'(t_hlt + 4 - run_t0);
    exp_ctl("halted", 8'b1000_0001, 8'hFF, 1'b1, rc_h);
    step();
    exp_ctl("halted_hold", 8'b1000_0001, 8'hFF, 1'b1, rc_h);
    step();

    // reload after halt restarts at address 0
    prog_valid = 1'b1;
    prog_data  = 32'h1234_5678;
    exp_wr(10'd0, prog_data);
    exp_ctl("halt_reload", 8'b1100_0001, 8'hFF, 1'b1, rc_h);
    step();
    prog_data = 32'h9ABC_DEF0;
    exp_wr(10'd1, prog_data);
    exp_ctl("reload_second", 8'b1100_0000, 8'hFF, 1'b1, rc_h);
    step();
    prog_valid = 1'b0;

    // reset asserted in DRAIN
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    id_ir = ins(6'b111111, 5'd0, 5'd0, 5'd0);
    step();
    step();
    exp_ctl("drain_pre_rst", 8'b0001_1010, 8'hFF, 1'b0, 32'd0);
    step();
    rst_n = 1'b0;
    exp_ctl("rst_mid_drain", 8'b1000_0000, 8'hFF, 1'b1, 32'd0);
    step();
    rst_n = 1'b1;
    id_ir = 32'd0;
    exp_ctl("post_rst", 8'b1000_0000, 8'hFF, 1'b1, 32'd0);
    step();

    // memory full: 1024 beats accepted, the 1025th refused
    for (int i = 0; i <= 1024; i++) begin
      prog_valid = 1'b1;
      wd = 32'hC000_0000 ^ 32'(i);
      prog_data = wd;
      if (i < 1024) exp_wr(10'(i), wd);
      if (i == 0)    exp_ctl("full_first",     8'b1100_0000, 8'hC0, 1'b0, 32'd0);
      if (i == 1023) exp_ctl("full_last_beat", 8'b1100_0000, 8'hC0, 1'b0, 32'd0);
      if (i == 1024) exp_ctl("full_blocked",   8'b0000_0000, 8'hC0, 1'b0, 32'd0);
      step();
    end
    exp_ctl("full_sticky", 8'b0000_0000, 8'hC0, 1'b0, 32'd0);
    step();
    run_start = 1'b1;
    step();
    run_start  = 1'b0;
    prog_valid = 1'b0;
    exp_ctl("run_after_full", 8'b0011_0000, 8'hFF, 1'b1, 32'd0);
    step();
    step();

    n_chk++;
    if (wq.size() != 0 || cq.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: got %0d writes and %0d controls pending, want 0 and 0",
               wq.size(), cq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
